// File: rtl/ysyx_22050854_csr_pkg.sv
// Shared constants for the ysyx_22050854 machine-mode CSR and trap unit:
// CSR addresses, csr_op encoding, interrupt cause codes and mstatus bit positions.
package ysyx_22050854_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_RD = 2'b00,
    CSR_OP_RW = 2'b01,
    CSR_OP_RS = 2'b10,
    CSR_OP_RC = 2'b11
  } csr_op_e;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

endpackage

// File: rtl/ysyx_22050854_csr_irq_arb.sv
// Fixed-priority machine interrupt arbiter: MEI > MSI > MTI.
// Purely combinational; o_code is 0 when nothing is pending.
module ysyx_22050854_csr_irq_arb
  import ysyx_22050854_csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_pend,
  output logic            o_any,
  output logic [4:0]      o_code
);

  localparam logic [XLEN-1:0] IRQ_BITS = XLEN'(12'h888);

  logic [XLEN-1:0] w_pend;

  assign w_pend = i_pend & IRQ_BITS;

  always_comb begin
    o_any  = |w_pend;
    o_code = '0;
    if (w_pend[IRQ_MEI])      o_code = IRQ_MEI;
    else if (w_pend[IRQ_MSI]) o_code = IRQ_MSI;
    else if (w_pend[IRQ_MTI]) o_code = IRQ_MTI;
  end

endmodule

// File: rtl/ysyx_22050854_csr_trap_unit.sv
// Machine-mode CSR file with interrupt arbitration, trap entry/return and mcycle/minstret.
// CSR reads are combinational; the fetch redirect is a registered one-cycle pulse.
module ysyx_22050854_csr_trap_unit
  import ysyx_22050854_csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_MTVEC = 'h8000_0000,
  parameter logic [XLEN-1:0] HARTID      = '0,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wsrc,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            irq_window,
  input  logic [XLEN-1:0] boundary_pc,
  input  logic            instret,
  input  logic            msip,
  input  logic            mtip,
  input  logic            meip,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            irq_taken
);

  localparam logic [XLEN-1:0] IRQ_BITS = XLEN'(12'h888);

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mcycle;
  logic [XLEN-1:0] r_minstret;
  logic            r_redirect_vld;
  logic [XLEN-1:0] r_redirect_pc;

  csr_op_e         w_op;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_pend;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_wval;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_irq_tgt;
  logic            w_mapped;
  logic            w_we;
  logic            w_irq_any;
  logic [4:0]      w_irq_code;

  assign w_op = csr_op_e'(csr_op);

  always_comb begin
    w_mstatus                      = '0;
    w_mstatus[MSTATUS_MIE]         = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE]        = r_mstatus_mpie;
    w_mstatus[MSTATUS_MPP_LO +: 2] = 2'b11;
    w_mip                          = '0;
    w_mip[IRQ_MSI]                 = msip;
    w_mip[IRQ_MTI]                 = mtip;
    w_mip[IRQ_MEI]                 = meip;
  end

  assign w_pend = w_mip & r_mie & {XLEN{r_mstatus_mie}};

  ysyx_22050854_csr_irq_arb #(.XLEN(XLEN)) u_irq_arb (
    .i_pend (w_pend),
    .o_any  (w_irq_any),
    .o_code (w_irq_code)
  );

  assign irq_taken = irq_window & w_irq_any & ~exc_valid;

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  w_rdata = w_mstatus;
      CSR_MIE:      w_rdata = r_mie;
      CSR_MTVEC:    w_rdata = r_mtvec;
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = r_mepc;
      CSR_MCAUSE:   w_rdata = r_mcause;
      CSR_MTVAL:    w_rdata = r_mtval;
      CSR_MIP:      w_rdata = w_mip;
      CSR_MCYCLE:   w_rdata = r_mcycle;
      CSR_MINSTRET: w_rdata = r_minstret;
      CSR_MHARTID:  w_rdata = HARTID;
      default:      w_mapped = 1'b0;
    endcase
  end

  assign csr_rdata   = w_rdata;
  assign csr_illegal = ~w_mapped | ((csr_addr == CSR_MHARTID) & (w_op != CSR_OP_RD));

  always_comb begin
    w_wval = w_rdata;
    case (w_op)
      CSR_OP_RW: w_wval = csr_wsrc;
      CSR_OP_RS: w_wval = w_rdata | csr_wsrc;
      CSR_OP_RC: w_wval = w_rdata & ~csr_wsrc;
      default:   w_wval = w_rdata;
    endcase
  end

  // Any trap or mret in the same cycle swallows the CSR instruction entirely.
  assign w_we = csr_valid & (w_op != CSR_OP_RD) & ~csr_illegal & ~exc_valid & ~irq_taken & ~mret;

  assign w_base    = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_irq_tgt = r_mtvec[0] ? (w_base + XLEN'({w_irq_code, 2'b00})) : w_base;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= RESET_MTVEC;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mscratch     <= '0;
      r_mcycle       <= '0;
      r_minstret     <= '0;
      r_redirect_vld <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_redirect_vld <= exc_valid | irq_taken | mret;
      r_mcycle       <= r_mcycle + XLEN'(1);
      r_minstret     <= r_minstret + XLEN'(instret);
      if (exc_valid || irq_taken) begin
        r_mepc         <= (exc_valid ? exc_pc : boundary_pc) & ~XLEN'(3);
        r_mcause       <= exc_valid ? XLEN'(exc_cause)
                                    : ((XLEN'(1) << (XLEN - 1)) | XLEN'(w_irq_code));
        r_mtval        <= exc_valid ? exc_tval : '0;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        r_redirect_pc  <= exc_valid ? w_base : w_irq_tgt;
      end else if (mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
        r_redirect_pc  <= r_mepc;
      end else if (w_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_wval[MSTATUS_MIE];
            r_mstatus_mpie <= w_wval[MSTATUS_MPIE];
          end
          CSR_MIE:      r_mie      <= w_wval & IRQ_BITS;
          CSR_MTVEC:    r_mtvec    <= {w_wval[XLEN-1:2], 1'b0, w_wval[0] & VECTORED_EN};
          CSR_MEPC:     r_mepc     <= {w_wval[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_wval;
          CSR_MTVAL:    r_mtval    <= w_wval;
          CSR_MSCRATCH: r_mscratch <= w_wval;
          CSR_MCYCLE:   r_mcycle   <= w_wval;
          CSR_MINSTRET: r_minstret <= w_wval;
          default: ;
        endcase
      end
    end
  end

  assign redirect_valid = r_redirect_vld;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ysyx_22050854_csr_trap_unit.sv
// Directed and randomized bench for the CSR/trap unit, checked against a map-based CSR model.
module tb_ysyx_22050854_csr_trap_unit;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RST_TVEC = 64'h8000_0000;
  localparam logic [63:0] HID      = 64'h5;

  logic        clock = 1'b0;
  logic        reset;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wsrc;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [63:0] exc_pc;
  logic [63:0] exc_tval;
  logic        mret;
  logic        irq_window;
  logic [63:0] boundary_pc;
  logic        instret;
  logic        msip, mtip, meip;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        irq_taken;

  always #5 clock = ~clock;

  ysyx_22050854_csr_trap_unit #(
    .XLEN(XLEN), .RESET_MTVEC(RST_TVEC), .HARTID(HID), .VECTORED_EN(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wsrc(csr_wsrc),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret(mret), .irq_window(irq_window), .boundary_pc(boundary_pc), .instret(instret),
    .msip(msip), .mtip(mtip), .meip(meip),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .irq_taken(irq_taken)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: CSR contents keyed by address, plus the expected redirect.
  logic [63:0] m_csr [int];
  logic        m_rv;
  logic [63:0] m_rpc;

  task automatic model_reset();
    m_csr.delete();
    m_csr['h300] = 64'h1800;  m_csr['h304] = 0;  m_csr['h305] = RST_TVEC;
    m_csr['h340] = 0;  m_csr['h341] = 0;  m_csr['h342] = 0;  m_csr['h343] = 0;
    m_csr['h344] = 0;  m_csr['hB00] = 0;  m_csr['hB02] = 0;  m_csr['hF14] = HID;
    m_rv  = 1'b0;
    m_rpc = 64'h0;
  endtask

  function automatic logic [63:0] wmask(input int a);
    case (a)
      'h300:   return 64'h88;
      'h304:   return 64'h888;
      'h344:   return 64'h0;
      'h305:   return ~64'h2;
      'h341:   return ~64'h3;
      'hF14:   return 64'h0;
      default: return ~64'h0;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input int a);
    if (a == 'h344)
      return ({63'b0, meip} << 11) | ({63'b0, mtip} << 7) | ({63'b0, msip} << 3);
    if (m_csr.exists(a)) return m_csr[a];
    return 64'h0;
  endfunction

  task automatic m_trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval);
    logic [63:0] ms;
    m_csr['h341] = pc & ~64'h3;
    m_csr['h342] = cause;
    m_csr['h343] = tval;
    ms = m_csr['h300];
    ms[7] = ms[3];
    ms[3] = 1'b0;
    m_csr['h300] = ms;
  endtask

  // One clock: check combinational and registered outputs, then advance the model.
  task automatic step();
    int          a;
    logic [63:0] rd, pend, ms, base, nv, m;
    logic [4:0]  code;
    bit          ill, irq;
    @(negedge clock);
    a    = int'(csr_addr);
    rd   = m_read(a);
    ill  = !m_csr.exists(a) || (a == 'hF14 && csr_op != 2'd0);
    ms   = m_csr['h300];
    pend = m_read('h344) & m_csr['h304];
    if (!ms[3]) pend = 64'h0;
    code = pend[11] ? 5'd11 : (pend[3] ? 5'd3 : 5'd7);
    irq  = irq_window && (pend != 0) && !exc_valid;
    check("rdata", csr_rdata, rd);
    check("illegal", csr_illegal, ill);
    check("irq_taken", irq_taken, irq);
    check("redirect_valid", redirect_valid, m_rv);
    if (m_rv) check("redirect_pc", redirect_pc, m_rpc);

    base = m_csr['h305] & ~64'h3;
    m_rv = exc_valid || irq || mret;
    if (exc_valid) begin
      m_rpc = base;
      m_trap(exc_pc, {59'b0, exc_cause}, exc_tval);
    end else if (irq) begin
      m_rpc = m_csr['h305][0] ? base + 64'(code) * 4 : base;
      m_trap(boundary_pc, (64'h1 << 63) | 64'(code), 64'h0);
    end else if (mret) begin
      m_rpc = m_csr['h341];
      ms[3] = ms[7];
      ms[7] = 1'b1;
      m_csr['h300] = ms;
    end
    m_csr['hB00] = m_csr['hB00] + 64'h1;
    m_csr['hB02] = m_csr['hB02] + 64'(instret);
    if (!exc_valid && !irq && !mret && csr_valid && csr_op != 2'd0 && !ill) begin
      case (csr_op)
        2'd1:    nv = csr_wsrc;
        2'd2:    nv = rd | csr_wsrc;
        default: nv = rd & ~csr_wsrc;
      endcase
      m = wmask(a);
      m_csr[a] = (m_csr[a] & ~m) | (nv & m);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    csr_valid = 0; csr_op = 2'd0; csr_addr = 12'h340; csr_wsrc = 0;
    exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
    mret = 0; irq_window = 0; boundary_pc = 0; instret = 0;
    msip = 0; mtip = 0; meip = 0;
  endtask

  task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [63:0] v);
    idle();
    csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wsrc = v;
    step();
    idle();
  endtask

  task automatic peek(input logic [11:0] a, output logic [63:0] v, output logic ill);
    csr_valid = 1'b0; csr_op = 2'd0; csr_addr = a;
    #1;
    v   = csr_rdata;
    ill = csr_illegal;
  endtask

  logic [11:0] addrs [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0};

  initial begin
    logic [63:0] v;
    logic        il;
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_redirect_pc", redirect_pc, 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    peek(12'h300, v, il); check("mstatus_rst", v, 64'h1800); check("mstatus_ill", il, 1'b0);
    peek(12'h305, v, il); check("mtvec_rst", v, RST_TVEC);
    step();
    peek(12'hF14, v, il); check("mhartid", v, HID); check("mhartid_ill", il, 1'b0);
    peek(12'h7C0, v, il); check("unmapped_ill", il, 1'b1);
    step();

    csr_do(2'd1, 12'h340, 64'hF0);
    csr_do(2'd2, 12'h340, 64'h0F);
    csr_do(2'd3, 12'h340, 64'h03);
    peek(12'h340, v, il); check("mscratch_final", v, 64'hFC);
    csr_do(2'd1, 12'hF14, 64'h123);
    peek(12'hF14, v, il); check("mhartid_kept", v, HID);

    csr_do(2'd2, 12'h300, 64'h8);
    exc_valid = 1; exc_cause = 5'd11; exc_pc = 64'h8000_0100;
    step();
    idle();
    check("ecall_rv", redirect_valid, 1'b1);
    check("ecall_pc", redirect_pc, 64'h8000_0000);
    peek(12'h341, v, il); check("ecall_mepc", v, 64'h8000_0100);
    peek(12'h300, v, il); check("ecall_mstatus", v, 64'h1880);
    step();
    mret = 1;
    step();
    idle();
    check("mret_pc", redirect_pc, 64'h8000_0100);
    peek(12'h300, v, il); check("mret_mstatus", v, 64'h1888);
    step();

    csr_do(2'd1, 12'h305, 64'h8000_0001);
    csr_do(2'd1, 12'h304, 64'h80);
    mtip = 1; irq_window = 1; boundary_pc = 64'h8000_0400;
    step();
    idle();
    check("vec_rv", redirect_valid, 1'b1);
    check("vec_pc", redirect_pc, 64'h8000_001C);
    peek(12'h342, v, il); check("vec_mcause", v, (64'h1 << 63) + 64'd7);
    mret = 1;
    step();
    idle();

    csr_do(2'd1, 12'h304, 64'h888);
    meip = 1; mtip = 1; irq_window = 1;
    exc_valid = 1; exc_cause = 5'd2; exc_pc = 64'h8000_0200; exc_tval = 64'hDEAD;
    step();
    check("both_pc", redirect_pc, 64'h8000_0000);
    peek(12'h342, v, il); check("both_mcause", v, 64'd2);
    exc_valid = 0; irq_window = 0; mret = 1;
    step();
    mret = 0; irq_window = 1; boundary_pc = 64'h8000_0300;
    step();
    check("mei_pc", redirect_pc, 64'h8000_002C);
    peek(12'h342, v, il); check("mei_mcause", v, (64'h1 << 63) + 64'd11);
    idle();
    mret = 1;
    step();
    idle();

    csr_do(2'd1, 12'hB00, ~64'h0);
    peek(12'hB00, v, il); check("mcycle_max", v, ~64'h0);
    step();
    peek(12'hB00, v, il); check("mcycle_wrap", v, 64'h0);
    csr_valid = 1; csr_op = 2'd1; csr_addr = 12'hB02; csr_wsrc = 64'h50; instret = 1;
    step();
    idle();
    peek(12'hB02, v, il); check("minstret_wr", v, 64'h50);
    instret = 1;
    step();
    idle();
    peek(12'hB02, v, il); check("minstret_inc", v, 64'h51);
    step();

    exc_valid = 1; exc_cause = 5'd5; exc_pc = 64'h8000_0800;
    step();
    idle();
    check("pre_rst_rv", redirect_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_rv", redirect_valid, 1'b0);
    check("mid_rst_pc", redirect_pc, 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 3000; i++) begin
      int k;
      k           = $urandom_range(0, 13);
      csr_valid   = $urandom_range(0, 1);
      csr_op      = 2'($urandom_range(0, 3));
      csr_addr    = (k < 12) ? addrs[k] : 12'($urandom);
      csr_wsrc    = {$urandom, $urandom};
      exc_valid   = ($urandom_range(0, 15) == 0);
      exc_cause   = 5'($urandom);
      exc_pc      = {$urandom, $urandom};
      exc_tval    = {$urandom, $urandom};
      mret        = ($urandom_range(0, 11) == 0);
      irq_window  = ($urandom_range(0, 3) == 0);
      boundary_pc = {$urandom, $urandom};
      instret     = $urandom_range(0, 1);
      msip        = ($urandom_range(0, 2) == 0);
      mtip        = ($urandom_range(0, 2) == 0);
      meip        = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
